writeback_regfile: RTL

Writeback stage and architectural register file for the single-issue core. It latches the 32-bit result from the load/ALU writeback select into a one-entry WB pipeline register and commits it to a 32 x 32 register file on the following clock edge. It also serves the two decode-stage read ports, bypassing the pending WB entry, and counts retired register-writing instructions.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/regfile_2r1w.sv | 39 +++
 rtl/writeback_regfile.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by decode, the writeback select and the
// writeback/register-file stage.
//   ADDR_W / OP_W / DATA_W : register index, operation-select and data widths
//   OP_*                   : bit positions inside the one-hot operation select
//   WB_MASK                : select bits whose instructions write a register
//                            (bit 2 LOAD, plus ALU/immediate/move paths);
//                            store (3) and control flow (14-17) never write
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 20;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;

  localparam logic [OP_W-1:0] WB_MASK = 20'hC3FF7;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: architectural register storage, two combinational read
// ports and one synchronous write port. Register 0 is hardwired to zero.
//   clk, reset          : clock, synchronous active-high clear of all registers
//   we, waddr, wdata    : write port, applied on the rising edge
//   raddr0/1, rdata0/1  : combinational read ports (index 0 reads zero)
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:N_REGS-1];

  // Reset has priority, so a write arriving with reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = (raddr0 == '0) ? '0 : mem[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: one-entry writeback pipeline register in front of the
// architectural register file, with bypass on both decode read ports and a
// retired-write counter.
//   clk, reset                  : clock, synchronous active-high reset
//   wb_valid_in, wb_result,
//   wb_rd, wb_select, wb_flush  : instruction arriving from the writeback select
//   rs1_addr/rs2_addr           : decode read indices
//   rs1_data/rs2_data           : combinational read data (bypassed)
//   wb_pending, wb_pending_rd   : WB entry will write a register at the next edge
//   retired_count               : committed register-writing instructions
//
// Handshake: valid-only, no ready. The stage never stalls; an instruction
// with wb_valid_in=1 and wb_flush=0 in cycle N is always accepted at edge N
// and commits at edge N+1. There is no backpressure path.
module writeback_regfile #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OP_W   = cpu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid_in,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [OP_W-1:0]   wb_select,
  input  logic              wb_flush,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_pending,
  output logic [ADDR_W-1:0] wb_pending_rd,
  output logic [31:0]       retired_count
);

  import cpu_pkg::*;

  localparam logic [OP_W-1:0] MASK = OP_W'(WB_MASK);

  logic              we_in;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              commit_we;
  logic [DATA_W-1:0] rf_rdata0;
  logic [DATA_W-1:0] rf_rdata1;

  // Multi-hot or empty selects are not errors: any masked bit means write.
  assign we_in = wb_valid_in & ~wb_flush & (|(wb_select & MASK));

  // WB register reloads every cycle; the stage has no stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= we_in;
      wb_rd_q    <= wb_rd;
      wb_data_q  <= wb_result;
    end
  end

  // Writes to r0 still retire (NOP-class ops); the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (wb_valid_q) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  assign commit_we     = wb_valid_q & (wb_rd_q != '0);
  assign wb_pending    = commit_we;
  assign wb_pending_rd = wb_rd_q;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (commit_we),
    .waddr  (wb_rd_q),
    .wdata  (wb_data_q),
    .raddr0 (rs1_addr),
    .raddr1 (rs2_addr),
    .rdata0 (rf_rdata0),
    .rdata1 (rf_rdata1)
  );

  // The pending WB entry is newer than the array, so it wins on a match.
  // commit_we already excludes r0, which keeps index 0 reading zero.
  assign rs1_data = (commit_we && (wb_rd_q == rs1_addr)) ? wb_data_q : rf_rdata0;
  assign rs2_data = (commit_we && (wb_rd_q == rs2_addr)) ? wb_data_q : rf_rdata1;

endmodule
